reflet_bus_bridge: RTL and testbench
====================================

# reflet_bus_bridge

Byte-stream-to-system-bus initiator for the Reflet microcontroller. It takes command bytes from a host link, such as a debug UART's receive stream, and turns them into single read or write accesses on the system bus that the peripheral block responds to. It returns an acknowledge byte or the read data on an outgoing byte stream. Bus ownership is requested from the CPU-side arbiter with a req/grant handshake.

## Interface
Parameters:
- wordsize, 16, bus data width in bits; must be a multiple of 8. WB = wordsize/8.
- base_addr_size, 16, bus address width in bits; must be a multiple of 8. AB = base_addr_size/8.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  command-stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  bridge accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- out_data  output  8  response byte.
- out_valid  output  1  out_data is valid; held stable until accepted.
- out_ready  input  1  sink accepts out_data this cycle.
- bus_req  output  1  request for bus ownership.
- bus_grant  input  1  arbiter grants the bus.
- enable  output  1  bus access strobe, driven to the peripheral enable input.
- addr  output  base_addr_size  bus address.
- data_out  output  wordsize  write data, driven to the peripheral data_in.
- data_in  input  wordsize  read data, driven from the peripheral data_out; combinational.
- write_en  output  1  write strobe.

## Operation
- Command framing:
  - Write is 0x57 ('W'), then AB address bytes, then WB data bytes.
  - Read is 0x52 ('R'), then AB address bytes.
  - Multi-byte fields are little-endian (LSB first).
- Responses:
  - Write: one byte, 0x4B ('K').
  - Read: WB data bytes, LSB first.
  - Any other command byte: 0x3F ('?'), then the bridge returns to IDLE.
- FSM states: IDLE, ADDR, DATA, REQ, ACCESS, RESP.
- State transitions:
  - IDLE: accept a byte. 'W' or 'R' goes to ADDR. Any other byte loads '?' into the response and goes to RESP with count 1.
  - ADDR: accept AB bytes into the address shift register. Then a write goes to DATA and a read goes to REQ.
  - DATA: accept WB bytes into the write-data register, then go to REQ.
  - REQ: bus_req=1. If bus_grant=1 this cycle, go to ACCESS next cycle.
  - ACCESS: exactly one cycle with bus_req=1 and enable=1. addr and data_out come from the registers. write_en=1 for a write, 0 for a read. For a read, data_in is captured into the response register on the closing edge. Then go to RESP; count is 1 for a write and WB for a read.
  - RESP: out_valid=1. On each out_ready the register shifts right by 8 and the count decrements. After the last byte is accepted, go to IDLE.
- in_ready=1 only in IDLE, ADDR and DATA. Input bytes arriving in other states are not consumed.
- Byte counter width is clog2(max(AB,WB)+1). It resets to 0 on each field entry.
- enable, write_en, addr and data_out are driven to 0 outside ACCESS, so the bus OR-combine stays clean.

## Timing
- Reset values: in_ready=0 while reset is asserted and 1 after release (IDLE). All other outputs are 0, including out_data, out_valid, bus_req, enable, write_en, addr and data_out. All registers clear.
- One byte is accepted per cycle, at most.
- Bus access timing:
  - bus_req rises on the cycle after the last command byte is accepted.
  - ACCESS occurs on the cycle after the first cycle in which bus_grant=1.
  - bus_req falls on the cycle after ACCESS.
- Latency: with bus_grant held at 1 and out_ready held at 1, the first out_valid comes 3 cycles after the final input byte. The sequence is REQ, ACCESS, then RESP.
- bus_grant is ignored outside REQ. Loss of grant during ACCESS does not abort the access.
- out_data and out_valid change only in the cycle after an accepted transfer, or on entry to RESP.
- Asserting reset mid-command or mid-response aborts immediately:
  - Partial fields are discarded.
  - bus_req and enable drop asynchronously.
  - No write is issued unless the write-enable edge has already occurred.

## Test plan
- Write: send 57 10 FF 34 12 with grant tied high. Expect one ACCESS cycle with addr=FF10, data_out=1234, write_en=1, then out byte 4B.
- Read: send 52 0C FF while the bus model returns ABCD at FF0C. Expect enable=1 and write_en=0 for one cycle, then out bytes CD, AB.
- Delayed grant: hold bus_grant=0 for 10 cycles after the command. Expect bus_req held high, enable=0 throughout, and ACCESS on the cycle after grant rises.
- Unknown command: send 41. Expect out byte 3F, no bus_req, then a following read command handled normally.
- Backpressure: during a read response, hold out_ready=0 for 5 cycles. Expect out_valid=1 with out_data stable at the LSB byte and in_ready=0 throughout.
- Reset mid-operation: assert reset after 57 10 FF 34. Expect all outputs 0 immediately and no bus access. After release, 52 10 FF completes normally.

Source files
------------

// File: rtl/reflet_bus_bridge.sv
// Byte-stream command decoder that turns 'W'/'R' frames into single system-bus accesses and streams back an ack or read data.
// Latency: REQ, ACCESS, RESP -> first response byte 3 cycles after the last command byte when the grant is immediate.
// Backpressure: in_ready is low outside IDLE/ADDR/DATA; out_data/out_valid are held until out_ready accepts each byte.
module reflet_bus_bridge #(
  parameter int wordsize       = 16,
  parameter int base_addr_size = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      bus_req,
  input  logic                      bus_grant,
  output logic                      enable,
  output logic [base_addr_size-1:0] addr,
  output logic [wordsize-1:0]       data_out,
  input  logic [wordsize-1:0]       data_in,
  output logic                      write_en
);

  localparam int WB   = wordsize / 8;
  localparam int AB   = base_addr_size / 8;
  localparam int MAXB = (AB > WB) ? AB : WB;
  localparam int CW   = $clog2(MAXB + 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_AB_LAST = CW'(AB - 1);
  localparam logic [CW-1:0] CNT_WB_LAST = CW'(WB - 1);
  localparam logic [CW-1:0] CNT_WB      = CW'(WB);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    REQ,
    ACCESS,
    RESP
  } state_t;

  state_t                    state_q, state_d;
  logic                      is_wr_q, is_wr_d;
  logic [base_addr_size-1:0] addr_q, addr_d;
  logic [wordsize-1:0]       wdata_q, wdata_d;
  logic [wordsize-1:0]       resp_q, resp_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic in_acc;
  logic out_acc;

  // Handshake decode: input is only taken while collecting a command, output only while responding.
  always_comb begin
    in_ready  = !reset && ((state_q == IDLE) || (state_q == ADDR) || (state_q == DATA));
    out_valid = (state_q == RESP);
    out_data  = resp_q[7:0];
    in_acc    = in_valid && in_ready;
    out_acc   = out_valid && out_ready;
  end

  // Bus-side outputs are forced to zero outside ACCESS so the shared OR-combined bus stays clean.
  always_comb begin
    bus_req  = (state_q == REQ) || (state_q == ACCESS);
    enable   = (state_q == ACCESS);
    write_en = (state_q == ACCESS) && is_wr_q;
    addr     = (state_q == ACCESS) ? addr_q : '0;
    data_out = (state_q == ACCESS) ? wdata_q : '0;
  end

  // Command parser / bus sequencer: next state plus field shift registers and response loading.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_acc) begin
          cnt_d = '0;
          if (in_data == CMD_WRITE) begin
            is_wr_d = 1'b1;
            state_d = ADDR;
          end else if (in_data == CMD_READ) begin
            is_wr_d = 1'b0;
            state_d = ADDR;
          end else begin
            // Unknown opcode: answer '?' and drop straight back to IDLE afterwards.
            resp_d      = '0;
            resp_d[7:0] = RSP_ERR;
            cnt_d       = CNT_ONE;
            state_d     = RESP;
          end
        end
      end

      ADDR: begin
        if (in_acc) begin
          // Little-endian field: each new byte enters at the top and slides down.
          addr_d = (addr_q >> 8) | (base_addr_size'(in_data) << (base_addr_size - 8));
          if (cnt_q == CNT_AB_LAST) begin
            cnt_d   = '0;
            state_d = is_wr_q ? DATA : REQ;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      DATA: begin
        if (in_acc) begin
          wdata_d = (wdata_q >> 8) | (wordsize'(in_data) << (wordsize - 8));
          if (cnt_q == CNT_WB_LAST) begin
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      REQ: begin
        if (bus_grant) begin
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        // Single-cycle access; grant is not re-checked here so a late drop cannot tear the cycle.
        state_d = RESP;
        if (is_wr_q) begin
          resp_d      = '0;
          resp_d[7:0] = RSP_ACK;
          cnt_d       = CNT_ONE;
        end else begin
          resp_d = data_in;
          cnt_d  = CNT_WB;
        end
      end

      RESP: begin
        if (out_acc) begin
          resp_d = resp_q >> 8;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial command or pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reflet_bus_bridge.sv
module tb_reflet_bus_bridge;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        bus_req;
  logic        bus_grant;
  logic        enable;
  logic [15:0] addr;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        write_en;

  reflet_bus_bridge #(
    .wordsize       (16),
    .base_addr_size (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .enable    (enable),
    .addr      (addr),
    .data_out  (data_out),
    .data_in   (data_in),
    .write_en  (write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model: drives read data only while strobed; FF0C holds ABCD, else the inverted address.
  assign data_in = enable ? ((addr == 16'hFF0C) ? 16'hABCD : ~addr) : 16'h0000;

  int n_vec;
  int n_mis;

  // Bus monitor
  int          acc_cnt;
  int          req_cnt;
  int          dirty;
  logic [15:0] acc_addr;
  logic [15:0] acc_wd;
  logic        acc_we;

  initial begin
    acc_cnt = 0; req_cnt = 0; dirty = 0;
    acc_addr = '0; acc_wd = '0; acc_we = 1'b0;
  end

  always @(negedge clk) begin
    if (enable) begin
      acc_cnt  = acc_cnt + 1;
      acc_addr = addr;
      acc_wd   = data_out;
      acc_we   = write_en;
    end
    if (bus_req) req_cnt = req_cnt + 1;
    if (!enable && (addr != 16'h0 || data_out != 16'h0 || write_en)) dirty = dirty + 1;
    if (enable && !bus_req) dirty = dirty + 1;
  end

  typedef struct packed {
    logic [2:0]       n_in;
    logic [4:0][7:0]  in_b;
    logic [1:0]       n_out;
    logic [1:0][7:0]  out_b;
    logic             acc;
    logic [15:0]      a;
    logic [15:0]      wd;
    logic             we;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [2:0] n_in, input logic [39:0] in_b,
                              input logic [1:0] n_out, input logic [15:0] out_b,
                              input logic acc, input logic [15:0] a,
                              input logic [15:0] wd, input logic we);
    vec_t v;
    v.n_in  = n_in;
    v.in_b  = in_b;
    v.n_out = n_out;
    v.out_b = out_b;
    v.acc   = acc;
    v.a     = a;
    v.wd    = wd;
    v.we    = we;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_in_ready"},  in_ready,  0);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_data"},  out_data,  0);
    chk({name, "_bus_req"},   bus_req,   0);
    chk({name, "_enable"},    enable,    0);
    chk({name, "_write_en"},  write_en,  0);
    chk({name, "_addr"},      addr,      0);
    chk({name, "_data_out"},  data_out,  0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Collects n response bytes; optionally stalls out_ready on the first byte and checks first-valid latency.
  task automatic collect(input int n, input logic [1:0][7:0] exp, input int stall, input int exp_lat);
    int t;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      t = 1;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (k == 0 && exp_lat >= 0) chk("resp_latency", t, exp_lat);
      chk("resp_valid", out_valid, 1);
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          chk("stall_data", out_data, exp[0]);
          chk("stall_in_ready", in_ready, 0);
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
        end
      end
      chk($sformatf("resp_byte%0d", k), out_data, exp[k]);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    chk("resp_done_valid", out_valid, 0);
    chk("resp_done_in_ready", in_ready, 1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int a0, r0;
    v = vecs[i];
    bus_grant = 1'b1;
    a0 = acc_cnt;
    r0 = req_cnt;
    for (int k = 0; k < int'(v.n_in); k++) send_byte(v.in_b[k]);
    collect(int'(v.n_out), v.out_b, 0, v.acc ? 3 : 1);
    chk($sformatf("v%0d_access_count", i), acc_cnt - a0, v.acc ? 1 : 0);
    chk($sformatf("v%0d_req_cycles", i), req_cnt - r0, v.acc ? 2 : 0);
    if (v.acc) begin
      chk($sformatf("v%0d_addr", i), acc_addr, v.a);
      chk($sformatf("v%0d_write_en", i), acc_we, v.we);
      if (v.we) chk($sformatf("v%0d_wdata", i), acc_wd, v.wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, bad;
    n_vec = 0;
    n_mis = 0;

    // {inputs (last byte leftmost), outputs (last byte leftmost), access expectations}
    vecs[0] = mk(3'd5, {8'h12, 8'h34, 8'hFF, 8'h10, 8'h57}, 2'd1, {8'h00, 8'h4B}, 1'b1, 16'hFF10, 16'h1234, 1'b1);
    vecs[1] = mk(3'd3, {8'h00, 8'h00, 8'hFF, 8'h0C, 8'h52}, 2'd2, {8'hAB, 8'hCD}, 1'b1, 16'hFF0C, 16'h0000, 1'b0);
    vecs[2] = mk(3'd1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h41}, 2'd1, {8'h00, 8'h3F}, 1'b0, 16'h0000, 16'h0000, 1'b0);
    vecs[3] = mk(3'd3, {8'h00, 8'h00, 8'hFF, 8'h0C, 8'h52}, 2'd2, {8'hAB, 8'hCD}, 1'b1, 16'hFF0C, 16'h0000, 1'b0);
    vecs[4] = mk(3'd3, {8'h00, 8'h00, 8'h12, 8'h00, 8'h52}, 2'd2, {8'hED, 8'hFF}, 1'b1, 16'h1200, 16'h0000, 1'b0);
    vecs[5] = mk(3'd5, {8'hBE, 8'hEF, 8'h55, 8'hAA, 8'h57}, 2'd1, {8'h00, 8'h4B}, 1'b1, 16'h55AA, 16'hBEEF, 1'b1);
    vecs[6] = mk(3'd1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h77}, 2'd1, {8'h00, 8'h3F}, 1'b0, 16'h0000, 16'h0000, 1'b0);
    vecs[7] = mk(3'd3, {8'h00, 8'h00, 8'h12, 8'h34, 8'h52}, 2'd2, {8'hED, 8'hCB}, 1'b1, 16'h1234, 16'h0000, 1'b0);

    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bus_grant = 1'b0;

    #1;
    chk_quiet("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_bus_req", bus_req, 0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Delayed grant: request must hold with no strobe until grant arrives.
    bus_grant = 1'b0;
    a0 = acc_cnt;
    send_byte(8'h52); send_byte(8'h0C); send_byte(8'hFF);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus_req || enable) bad++;
    end
    chk("dly_req_hold", bad, 0);
    bus_grant = 1'b1;
    @(negedge clk);
    chk("dly_enable", enable, 1);
    chk("dly_addr", addr, 16'hFF0C);
    chk("dly_we", write_en, 0);
    @(negedge clk);
    chk("dly_enable_off", enable, 0);
    chk("dly_req_off", bus_req, 0);
    collect(2, {8'hAB, 8'hCD}, 0, -1);
    chk("dly_access_count", acc_cnt - a0, 1);

    // Backpressure on the first read byte.
    send_byte(8'h52); send_byte(8'h0C); send_byte(8'hFF);
    collect(2, {8'hAB, 8'hCD}, 5, 3);

    // Reset in the middle of a write's data field: nothing reaches the bus.
    a0 = acc_cnt;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hFF); send_byte(8'h34);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_access", acc_cnt - a0, 0);
    send_byte(8'h52); send_byte(8'h10); send_byte(8'hFF);
    collect(2, {8'h00, 8'hEF}, 0, 3);
    chk("midrst_read_count", acc_cnt - a0, 1);
    chk("midrst_read_addr", acc_addr, 16'hFF10);
    chk("midrst_read_we", acc_we, 0);

    // Reset while requesting the bus: bus_req must drop without waiting for a clock edge.
    bus_grant = 1'b0;
    send_byte(8'h52); send_byte(8'h0C); send_byte(8'hFF);
    @(negedge clk);
    chk("reqrst_req_before", bus_req, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("reqrst_req_async", bus_req, 0);
    chk("reqrst_enable", enable, 0);
    @(negedge clk);
    reset = 1'b0;
    bus_grant = 1'b1;
    a0 = acc_cnt;
    repeat (3) @(negedge clk);
    chk("reqrst_no_access", acc_cnt - a0, 0);

    chk("bus_idle_clean", dirty, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
